// File: rtl/shift_pkg.sv
// Shared encodings for the iterative barrel-shift sequencer: operation codes,
// FSM state encoding and the fill-bit rule for right shifts.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Arithmetic right shifts replicate the sign; every other op fills with zero.
  function automatic logic fill_bit(input op_e op, input logic msb);
    return (op == OP_SRA) ? msb : 1'b0;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One conditional shift by 2^idx_i positions, left (zero fill) or right
// (fill_i replicated into the vacated MSBs). Purely combinational.
module shift_stage #(
  parameter int WIDTH = 32,
  parameter int IW    = 3
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             fill_i,
  input  logic             left_i,
  input  logic             en_i,
  input  logic [IW-1:0]    idx_i,
  output logic [WIDTH-1:0] data_o
);

  logic [31:0]        amt;
  logic [2*WIDTH-1:0] ext_r;

  always_comb begin
    amt    = 32'd1 << idx_i;
    ext_r  = {{WIDTH{fill_i}}, data_i} >> amt;
    data_o = data_i;
    if (en_i) begin
      data_o = left_i ? (data_i << amt) : ext_r[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one shift_stage reused per cycle, one stage per bit of
// the latched shift amount, then a final cycle that saturates oversize shifts.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | ready for a request; Z shows the last result (0 after reset)
//   ST_SHIFT | stages 0..SHW-1 applied, then one saturation cycle
//   ST_DONE  | result held on Z with out_valid until out_ready
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             busy
);

  localparam int CW = $clog2(SHW + 1);
  localparam logic [CW-1:0] SAT_STAGE = CW'(SHW);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] y_q, y_d;
  op_e              op_q, op_d;

  logic             stage_en;
  logic             stage_fill;
  logic [WIDTH-1:0] stage_out;
  logic             y_over;
  logic [WIDTH-1:0] sat_val;

  assign stage_en   = y_q[cnt_q] && (op_q != OP_RSV);
  assign stage_fill = fill_bit(op_q, work_q[WIDTH-1]);
  assign y_over     = |(y_q >> SHW);
  // Sign survives every arithmetic stage, so the working MSB is still X's MSB.
  assign sat_val    = {WIDTH{stage_fill}};

  shift_stage #(
    .WIDTH(WIDTH),
    .IW   (CW)
  ) u_stage (
    .data_i(work_q),
    .fill_i(stage_fill),
    .left_i(op_q == OP_SLL),
    .en_i  (stage_en),
    .idx_i (cnt_q),
    .data_o(stage_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      y_q     <= '0;
      op_q    <= OP_SLL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      y_q     <= y_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == SAT_STAGE) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    work_d = work_q;
    y_d    = y_q;
    op_d   = op_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d   = op_e'(op);
          y_d    = Y;
          work_d = X;
          cnt_d  = '0;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == SAT_STAGE) begin
          cnt_d = '0;
          if (y_over && (op_q != OP_RSV)) work_d = sat_val;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          work_d = stage_out;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    Z         = work_q;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: a vector table for the shift functions
// plus hand-written sequences for hold, reset abort and back-to-back traffic.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op_r = 2'b00;
  logic [31:0] x_r = '0;
  logic [31:0] y_r = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] z_w;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } vec_t;

  vec_t vecs[$];

  shift_sequencer #(.WIDTH(32), .SHW(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op_r),
    .X        (x_r),
    .Y        (y_r),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Z        (z_w),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] o, input logic [31:0] x,
                              input logic [31:0] y, input logic [31:0] z);
    vec_t v;
    v.op = o; v.x = x; v.y = y; v.z = z;
    return v;
  endfunction

  // Issues one request from IDLE, scrambles inputs while it runs, returns the
  // result and the number of cycles from the accepting edge to out_valid.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] z, output int lat);
    @(negedge clk);
    op_r = o; x_r = x; y_r = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_r = $urandom; y_r = $urandom; op_r = 2'($urandom_range(0, 3));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    z = z_w;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] z;
    int          lat;
    int          seen;
    int          acc_cyc[3];
    int          res_cyc[3];
    logic [31:0] res_z[3];
    int          n_acc;
    int          n_res;
    vec_t        b2b[3];

    vecs.push_back(mk(2'b00, 32'hFFFFFFFF, 32'd6,   32'hFFFFFFC0));
    vecs.push_back(mk(2'b01, 32'hFFFFFFFF, 32'd1,   32'h7FFFFFFF));
    vecs.push_back(mk(2'b01, 32'hFFFFFFFF, 32'd2,   32'h3FFFFFFF));
    vecs.push_back(mk(2'b01, 32'hFFFFFFFF, 32'd4,   32'h0FFFFFFF));
    vecs.push_back(mk(2'b01, 32'hFFFFFFFF, 32'd8,   32'h00FFFFFF));
    vecs.push_back(mk(2'b01, 32'hFFFFFFFF, 32'd16,  32'h0000FFFF));
    vecs.push_back(mk(2'b01, 32'hFFFFFFFF, 32'd32,  32'h00000000));
    vecs.push_back(mk(2'b10, 32'h80000000, 32'd31,  32'hFFFFFFFF));
    vecs.push_back(mk(2'b10, 32'h80000000, 32'd40,  32'hFFFFFFFF));
    vecs.push_back(mk(2'b01, 32'h80000000, 32'd40,  32'h00000000));
    vecs.push_back(mk(2'b11, 32'h12345678, 32'd3,   32'h12345678));
    vecs.push_back(mk(2'b11, 32'hCAFEBABE, 32'd100, 32'hCAFEBABE));
    vecs.push_back(mk(2'b00, 32'hA5A5A5A5, 32'd0,   32'hA5A5A5A5));
    vecs.push_back(mk(2'b10, 32'h7F000000, 32'd4,   32'h07F00000));
    vecs.push_back(mk(2'b10, 32'h80000000, 32'd4,   32'hF8000000));
    vecs.push_back(mk(2'b00, 32'h00000001, 32'd31,  32'h80000000));
    vecs.push_back(mk(2'b00, 32'h00000001, 32'd32,  32'h00000000));
    vecs.push_back(mk(2'b00, 32'h0000F00F, 32'd21,  32'h01E00000));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_z",         z_w,            32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].x, vecs[i].y, z, lat);
      chk($sformatf("vec%0d_z", i),   z,         vecs[i].z);
      chk($sformatf("vec%0d_lat", i), 32'(lat),  32'd6);
      chk($sformatf("vec%0d_idle", i), 32'(in_ready), 32'd1);
    end

    // Hold in DONE with out_ready low while inputs churn
    @(negedge clk);
    op_r = 2'b01; x_r = 32'hFFFFFFFF; y_r = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold_lat", 32'(lat), 32'd6);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      x_r = $urandom; y_r = $urandom; op_r = 2'($urandom_range(0, 3));
      in_valid = ~in_valid;
      @(posedge clk); #1;
      chk($sformatf("hold%0d_z", c),        z_w,             32'h0FFFFFFF);
      chk($sformatf("hold%0d_in_ready", c), 32'(in_ready),   32'd0);
      chk($sformatf("hold%0d_out_valid", c), 32'(out_valid), 32'd1);
    end
    // Consume with in_valid high: must not be accepted on the same edge
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("consume_in_ready",  32'(in_ready),  32'd1);
    chk("consume_out_valid", 32'(out_valid), 32'd0);
    chk("consume_busy",      32'(busy),      32'd0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;

    // Reset during the third SHIFT cycle
    @(negedge clk);
    op_r = 2'b00; x_r = 32'hFFFFFFFF; y_r = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_busy_shift", 32'(busy), 32'd1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready",  32'(in_ready),  32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy",      32'(busy),      32'd0);
    chk("abort_z",         z_w,            32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    chk("abort_z_after",   z_w,       32'd0);

    // Back-to-back with out_ready tied high
    b2b[0] = mk(2'b00, 32'h0000000F, 32'd4,  32'h000000F0);
    b2b[1] = mk(2'b10, 32'hF0000000, 32'd8,  32'hFFF00000);
    b2b[2] = mk(2'b01, 32'h12345678, 32'd12, 32'h00012345);
    n_acc = 0;
    n_res = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid && n_res < 3) begin
        res_cyc[n_res] = c;
        res_z[n_res]   = z_w;
        n_res++;
      end
      if (in_ready && n_acc < 3) begin
        op_r = b2b[n_acc].op; x_r = b2b[n_acc].x; y_r = b2b[n_acc].y;
        in_valid = 1'b1;
        acc_cyc[n_acc] = c;
        n_acc++;
      end else if (in_ready) begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_accepts", 32'(n_acc), 32'd3);
    chk("b2b_results", 32'(n_res), 32'd3);
    if (n_acc == 3 && n_res == 3) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("b2b%0d_z", k),   res_z[k],                     b2b[k].z);
        chk($sformatf("b2b%0d_lat", k), 32'(res_cyc[k] - acc_cyc[k]), 32'd7);
      end
      chk("b2b_period01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd8);
      chk("b2b_period12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd8);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter SHW, default 5, shift-amount stage count; SHALL equal log2(WIDTH).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  sequencer can accept a request this cycle.
REQ-007 op  input  2  shift operation: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
REQ-008 X  input  WIDTH  operand to shift.
REQ-009 Y  input  WIDTH  shift amount, unsigned.
REQ-010 out_valid  output  1  Z holds a completed result.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 Z  output  WIDTH  shifted result.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT, DONE.
REQ-015 In IDLE, in_ready SHALL be 1; a transfer occurs on in_valid && in_ready.
REQ-016 On transfer, op, X and Y SHALL be latched, stage counter cleared to 0, state -> SHIFT.
REQ-017 In SHIFT, stage k SHALL shift the working register by 2^k positions if latched Y[k]=1, else hold it; counter increments each cycle.
REQ-018 SLL SHALL fill with 0 from the LSB side; SRL SHALL fill with 0 from the MSB side; SRA SHALL fill with the latched X[WIDTH-1].
REQ-019 After stage SHW-1, state SHALL -> DONE; out_valid SHALL assert exactly SHW+1 cycles after the accepting edge (6 cycles at default).
REQ-020 If any latched Y bit at position >= SHW is 1, the result SHALL be all-zero for SLL/SRL and all-copies of X[WIDTH-1] for SRA, with unchanged latency.
REQ-021 op=11 SHALL be accepted and SHALL produce Z = X unshifted, unchanged latency.
REQ-022 In DONE, out_valid=1 and Z SHALL stay stable until out_valid && out_ready; then state -> IDLE.
REQ-023 in_ready SHALL be 0 in SHIFT and DONE; in_valid there SHALL be ignored and X/Y/op changes SHALL not affect the running operation.
REQ-024 A new request SHALL not be accepted in the same cycle a result is consumed (one idle cycle between operations).
REQ-025 Y=0 SHALL still take the full SHW-cycle SHIFT phase and return Z = X.

Reset
REQ-026 rst SHALL have priority over all other inputs and, on the clock edge, force state IDLE, counter 0, working register 0.
REQ-027 After reset: in_ready=1, out_valid=0, busy=0, Z=0.
REQ-028 Reset asserted mid-SHIFT or in DONE SHALL abort the operation; no result SHALL be presented afterward.

Structure
REQ-029 Package shift_pkg SHALL hold the op encodings (OP_SLL, OP_SRL, OP_SRA) and the FSM state encoding.
REQ-030 One combinational sub-module shift_stage (inputs: data, fill bit, direction, enable, stage index; output: data) SHALL implement a single conditional 2^k shift; the sequencer reuses one instance every cycle.
REQ-031 Working register, counter and latched op/Y SHALL be the only state; no combinational path from in_valid to out_valid.

Verification
REQ-032 Reset then X=32'hFFFFFFFF, op=SLL, Y=6 -> out_valid 6 cycles after accept, Z=32'hFFFFFFC0.
REQ-033 Sweep Y=1,2,4,8,16,32 with X=32'hFFFFFFFF, op=SRL -> Z=7FFFFFFF, 3FFFFFFF, 0FFFFFFF, 00FFFFFF, 0000FFFF, 00000000.
REQ-034 X=32'h80000000, op=SRA, Y=31 -> Z=32'hFFFFFFFF; same with Y=40 -> Z=32'hFFFFFFFF; op=SRL, Y=40 -> Z=0.
REQ-035 Hold out_ready=0 for 10 cycles in DONE while toggling X/Y/in_valid -> Z stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-036 Assert rst on the 3rd SHIFT cycle -> next cycle in_ready=1, out_valid=0, busy=0, Z=0; no stale result appears.
REQ-037 Back-to-back requests with out_ready tied 1 -> one result per 8 cycles, results in request order.
